// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a single-clock show-ahead FIFO wrapped around a
// simple dual-port RAM with combinational read; the RAM itself lives outside this block.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  err_clr,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] count_q;
    logic [ADDR_WIDTH:0] count_nxt;
    logic                overflow_q;
    logic                underflow_q;
    logic                push_ok;
    logic                pop_ok;
    logic                overflow_set;
    logic                underflow_set;
    logic [31:0]         count_ext;

    // A push into a full FIFO is still legal when a pop frees the same slot this cycle.
    assign push_ok       = push & (~full | pop);
    assign pop_ok        = pop & ~empty;
    assign overflow_set  = push & full & ~pop;
    assign underflow_set = pop & empty;

    assign ram_we    = push_ok;
    assign ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];

    // Flags decode only from the registered count, so push/pop never glitch them.
    assign count_ext    = 32'(count_q);
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_ext >= 32'(AF_LEVEL));
    assign almost_empty = (count_ext <= 32'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_nxt;
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the single-clock FIFO built around the simple dual-port RAM.
- Sits directly upstream of the RAM and drives its write_enable, write_addr and read_addr. Data goes straight from the producer to the RAM data_in; the consumer reads RAM data_out.
- The RAM read is combinational, so the FIFO is show-ahead: the head word is on RAM data_out whenever empty=0.
- Also provides occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  producer write request; data is presented on RAM data_in in the same cycle.
- pop  in  1  consumer read request; the consumer samples RAM data_out in the same cycle.
- err_clr  in  1  synchronous clear of overflow/underflow.
- ram_we  out  1  to RAM write_enable.
- ram_waddr  out  ADDR_WIDTH  to RAM write_addr.
- ram_raddr  out  ADDR_WIDTH  to RAM read_addr.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- State registers: wr_ptr and rd_ptr (ADDR_WIDTH+1 bits each, MSB is the wrap bit), count, overflow, underflow.
- Reset (async, rst=1): all registers clear to 0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0 (unless AF_LEVEL is outside its legal range), ram_we=0, ram_waddr=0, ram_raddr=0, count=0, overflow=0, underflow=0.
- A rst asserted mid-operation discards all contents immediately. RAM contents are not cleared and not needed.
- Accept rules, evaluated on flags before the clock edge:
  - push_ok = push & (~full | pop)
  - pop_ok = pop & ~empty
- ram_we = push_ok (combinational). ram_waddr = wr_ptr[ADDR_WIDTH-1:0]. ram_raddr = rd_ptr[ADDR_WIDTH-1:0].
- Each rising edge:
  - wr_ptr += push_ok
  - rd_ptr += pop_ok
  - count += push_ok - pop_ok
- Pointers wrap modulo 2*DEPTH via natural overflow of ADDR_WIDTH+1 bits. Address bits wrap DEPTH-1 -> 0.
- full, empty, almost_full, almost_empty are decoded combinationally from registered count only, so they are glitch-free relative to push/pop.
- Latency:
  - A word pushed at edge N is visible on RAM data_out, with empty=0, in cycle N+1.
  - A pop in cycle N advances to the next word after edge N.
- Simultaneous events:
  - Full with push&pop: both accepted. Write goes to the slot being vacated (the RAM reads the old value combinationally before the edge). count unchanged, no overflow.
  - Empty with push&pop: push accepted, pop rejected, underflow set, count becomes 1.
  - Otherwise with push&pop: both accepted, count unchanged.
- Errors:
  - overflow sets on push & full & ~pop.
  - underflow sets on pop & empty.
  - Both are sticky until rst or err_clr. If a set condition and err_clr occur in the same cycle, set wins.
- A rejected operation never moves a pointer or changes count.
- Invariant: count == wr_ptr - rd_ptr (mod 2*DEPTH) at all times.

Test Plan (defaults, DEPTH=16):
- Reset, then 16 pushes of 0x00..0x0F -> count=16, full=1, almost_full=1 from count=14 onward. A 17th push gives ram_we=0 and overflow=1 next cycle; wr_ptr is unchanged.
- From full, 16 pops -> data_out reads 0x00..0x0F in order; empty=1 after the last pop; almost_empty=1 once count <= 2. A further pop sets underflow=1 and leaves rd_ptr unchanged.
- Wrap-around: push 10, pop 10, push 12 -> ram_waddr sequence goes 10..15 then 0..5; readback is in order; count=12, full=0.
- Full plus push&pop for 5 cycles -> count stays 16, full stays 1, no overflow, FIFO order preserved. Empty plus push&pop -> count=1, underflow=1.
- err_clr pulse -> flags clear next cycle. err_clr in the same cycle as a new overflow -> overflow stays 1.
- Assert rst while count=7 -> count=0, empty=1, pointers 0 immediately with no clock edge; a push after release writes address 0.
